// File: rtl/uart_pkg.sv
// uart_pkg: parity modes, receiver/transmitter state encoding and baud divider helper
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_BREAK
    } state_t;

    // Rounded clock divider giving one tick per oversample slot
    function automatic int calc_div(input int clk_hz, input int baud, input int os);
        return (clk_hz + (baud * os) / 2) / (baud * os);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: divides clk into one-cycle oversample ticks, re-phased by restart
module uart_baud_tick #(
    parameter int DIV = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic tick
);

    localparam int CW = DIV > 1 ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt;

    assign tick = cnt == CW'(DIV - 1);

    // Free-running divider; restart zeroes it so ticks line up with the start edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (restart || tick)
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/uart_rx_param.sv
// uart_rx_param: oversampled UART receiver with majority voting, error flags and valid/ready output
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int CLK_HZ     = 100_000_000,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 RsRx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun
);

    localparam int DIV = calc_div(CLK_HZ, BAUD, OVERSAMPLE);
    localparam int SW  = $clog2(OVERSAMPLE);
    localparam int BW  = $clog2(DATA_BITS + 1);
    localparam logic [SW-1:0] S0   = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] S1   = SW'(OVERSAMPLE / 2);
    localparam logic [SW-1:0] S2   = SW'(OVERSAMPLE / 2 + 1);
    localparam logic [SW-1:0] SMAX = SW'(OVERSAMPLE - 1);

    state_t               state, nxt;
    logic                 s1, s2, s2_d;
    logic                 fall, restart, tick, mid, bitv, last_bit, par_ok;
    logic [SW-1:0]        scnt;
    logic [1:0]           samp;
    logic [BW-1:0]        bcnt;
    logic [DATA_BITS-1:0] sh;
    logic                 pbit;
    logic                 p_err, f_err, ovr, load;

    uart_baud_tick #(.DIV(DIV)) u_tick (
        .clk     (clk),
        .rst     (rst),
        .restart (restart),
        .tick    (tick)
    );

    assign fall     = s2_d & ~s2;
    assign restart  = state == ST_IDLE && fall;
    assign mid      = tick && scnt == S2;
    assign bitv     = (samp[0] & samp[1]) | (samp[0] & s2) | (samp[1] & s2);
    assign last_bit = bcnt == BW'(DATA_BITS - 1);
    assign par_ok   = PARITY == PAR_ODD  ?  ^{sh, pbit} :
                      PARITY == PAR_EVEN ? ~^{sh, pbit} : 1'b1;

    // Two-flop synchroniser plus one delayed copy for falling-edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            {s2_d, s2, s1} <= 3'b111;
        else
            {s2_d, s2, s1} <= {s2, s1, RsRx};
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= ST_IDLE;
        else
            state <= nxt;
    end

    // Next state and stop-bit verdict; every state acts at the third centre sample
    always_comb begin
        nxt   = state;
        f_err = 1'b0;
        p_err = 1'b0;
        ovr   = 1'b0;
        load  = 1'b0;
        case (state)
            ST_IDLE:   nxt = fall ? ST_START : ST_IDLE;
            ST_START:  if (mid) nxt = bitv ? ST_IDLE : ST_DATA;
            ST_DATA:   if (mid && last_bit) nxt = PARITY != PAR_NONE ? ST_PARITY : ST_STOP;
            ST_PARITY: if (mid) nxt = ST_STOP;
            ST_STOP:   if (mid) nxt = bitv ? ST_IDLE : ST_BREAK;
            ST_BREAK:  if (s2) nxt = ST_IDLE;
            default:   nxt = ST_IDLE;
        endcase
        if (state == ST_STOP && mid) begin
            f_err = !bitv;
            p_err = bitv && !par_ok;
            ovr   = bitv && par_ok && rx_valid && !rx_ready;
            load  = bitv && par_ok && !(rx_valid && !rx_ready);
        end
    end

    // Oversample slot counter, centre samples, data shifter and parity capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scnt <= '0;
            samp <= 2'b11;
            bcnt <= '0;
            sh   <= '0;
            pbit <= 1'b0;
        end else begin
            if (restart)
                scnt <= '0;
            else if (tick && state != ST_IDLE)
                scnt <= scnt == SMAX ? '0 : scnt + 1'b1;
            if (tick && scnt == S0)
                samp[0] <= s2;
            if (tick && scnt == S1)
                samp[1] <= s2;
            if (restart)
                bcnt <= '0;
            else if (state == ST_DATA && mid)
                bcnt <= bcnt + 1'b1;
            if (state == ST_DATA && mid)
                sh <= {bitv, sh[DATA_BITS-1:1]};
            if (state == ST_PARITY && mid)
                pbit <= bitv;
        end
    end

    // Output holding register with handshake and one-cycle error pulses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            parity_err <= p_err;
            frame_err  <= f_err;
            overrun    <= ovr;
            if (load) begin
                rx_data  <= sh;
                rx_valid <= 1'b1;
            end else if (rx_valid && rx_ready) begin
                rx_data  <= '0;
                rx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_param.sv
// tb_uart_rx_param: directed checks of the 8N1 and 7E1 receiver configurations
module tb_uart_rx_param;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rsrx8 = 1'b1, rsrx7 = 1'b1, rdy8 = 1'b1, rdy7 = 1'b1;
    logic [7:0] data8;
    logic [6:0] data7;
    logic       val8, val7, pe8, pe7, fe8, fe7, ov8, ov7;

    int n_chk = 0;
    int n_fail = 0;
    int acc8 = 0, vcyc8 = 0, pe8n = 0, fe8n = 0, ov8n = 0;
    int acc7 = 0, pe7n = 0, fe7n = 0, ov7n = 0;
    logic [7:0] log8 [0:63];
    logic [6:0] log7 [0:63];

    always #5 clk = ~clk;

    uart_rx_param #(.CLK_HZ(1_600_000), .BAUD(10_000), .OVERSAMPLE(16), .DATA_BITS(8), .PARITY(0)) u8 (
        .clk(clk), .rst(rst), .RsRx(rsrx8), .rx_data(data8), .rx_valid(val8), .rx_ready(rdy8),
        .parity_err(pe8), .frame_err(fe8), .overrun(ov8)
    );

    uart_rx_param #(.CLK_HZ(1_600_000), .BAUD(10_000), .OVERSAMPLE(16), .DATA_BITS(7), .PARITY(2)) u7 (
        .clk(clk), .rst(rst), .RsRx(rsrx7), .rx_data(data7), .rx_valid(val7), .rx_ready(rdy7),
        .parity_err(pe7), .frame_err(fe7), .overrun(ov7)
    );

    // Monitor: log accepted bytes and count pulses
    always @(negedge clk) begin
        if (val8) vcyc8 <= vcyc8 + 1;
        if (val8 && rdy8) begin log8[acc8 % 64] <= data8; acc8 <= acc8 + 1; end
        if (pe8) pe8n <= pe8n + 1;
        if (fe8) fe8n <= fe8n + 1;
        if (ov8) ov8n <= ov8n + 1;
        if (val7 && rdy7) begin log7[acc7 % 64] <= data7; acc7 <= acc7 + 1; end
        if (pe7) pe7n <= pe7n + 1;
        if (fe7) fe7n <= fe7n + 1;
        if (ov7) ov7n <= ov7n + 1;
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic send8(input logic [7:0] d, input int per, input logic stop);
        rsrx8 = 1'b0;
        repeat (per) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rsrx8 = d[i];
            repeat (per) @(negedge clk);
        end
        rsrx8 = stop;
        repeat (per) @(negedge clk);
    endtask

    task automatic send7(input logic [6:0] d, input logic p, input int per);
        rsrx7 = 1'b0;
        repeat (per) @(negedge clk);
        for (int i = 0; i < 7; i++) begin
            rsrx7 = d[i];
            repeat (per) @(negedge clk);
        end
        rsrx7 = p;
        repeat (per) @(negedge clk);
        rsrx7 = 1'b1;
        repeat (per) @(negedge clk);
    endtask

    task automatic test_reset;
        idle(4);
        n_chk++; if (val8 !== 1'b0) begin n_fail++; $display("FAIL reset_val8: got %b exp 0", val8); end
        n_chk++; if (data8 !== 8'h00) begin n_fail++; $display("FAIL reset_data8: got %h exp 00", data8); end
        n_chk++; if ({pe8, fe8, ov8} !== 3'b000) begin n_fail++; $display("FAIL reset_err8: got %b exp 000", {pe8, fe8, ov8}); end
        n_chk++; if (val7 !== 1'b0) begin n_fail++; $display("FAIL reset_val7: got %b exp 0", val7); end
        n_chk++; if (data7 !== 7'h00) begin n_fail++; $display("FAIL reset_data7: got %h exp 00", data7); end
        rst = 1'b0;
        idle(50);
    endtask

    task automatic test_basic;
        int a, v, e;
        a = acc8; v = vcyc8; e = pe8n + fe8n + ov8n;
        send8(8'hA5, 160, 1'b1);
        idle(200);
        n_chk++; if (acc8 - a !== 1) begin n_fail++; $display("FAIL basic_count: got %0d exp 1", acc8 - a); end
        n_chk++; if (log8[a % 64] !== 8'hA5) begin n_fail++; $display("FAIL basic_data: got %h exp a5", log8[a % 64]); end
        n_chk++; if (vcyc8 - v !== 1) begin n_fail++; $display("FAIL basic_valid_cycles: got %0d exp 1", vcyc8 - v); end
        n_chk++; if (pe8n + fe8n + ov8n - e !== 0) begin n_fail++; $display("FAIL basic_errors: got %0d exp 0", pe8n + fe8n + ov8n - e); end
    endtask

    task automatic test_parity;
        int a, p, f;
        a = acc7; p = pe7n; f = fe7n;
        send7(7'h53, 1'b0, 160);
        idle(200);
        n_chk++; if (acc7 - a !== 1) begin n_fail++; $display("FAIL par_good_count: got %0d exp 1", acc7 - a); end
        n_chk++; if (log7[a % 64] !== 7'h53) begin n_fail++; $display("FAIL par_good_data: got %h exp 53", log7[a % 64]); end
        n_chk++; if (pe7n - p !== 0) begin n_fail++; $display("FAIL par_good_perr: got %0d exp 0", pe7n - p); end
        send7(7'h53, 1'b1, 160);
        idle(200);
        n_chk++; if (pe7n - p !== 1) begin n_fail++; $display("FAIL par_bad_perr: got %0d exp 1", pe7n - p); end
        n_chk++; if (acc7 - a !== 1) begin n_fail++; $display("FAIL par_bad_count: got %0d exp 1", acc7 - a); end
        n_chk++; if (val7 !== 1'b0) begin n_fail++; $display("FAIL par_bad_valid: got %b exp 0", val7); end
        n_chk++; if (fe7n - f !== 0) begin n_fail++; $display("FAIL par_bad_ferr: got %0d exp 0", fe7n - f); end
    endtask

    task automatic test_glitch_break;
        int a, f, e;
        a = acc8; f = fe8n; e = pe8n + ov8n;
        rsrx8 = 1'b0;
        idle(40);
        rsrx8 = 1'b1;
        idle(400);
        n_chk++; if (acc8 - a !== 0) begin n_fail++; $display("FAIL glitch_count: got %0d exp 0", acc8 - a); end
        n_chk++; if (fe8n - f !== 0) begin n_fail++; $display("FAIL glitch_ferr: got %0d exp 0", fe8n - f); end
        send8(8'h81, 160, 1'b0);
        idle(2000);
        n_chk++; if (fe8n - f !== 1) begin n_fail++; $display("FAIL break_ferr: got %0d exp 1", fe8n - f); end
        n_chk++; if (acc8 - a !== 0) begin n_fail++; $display("FAIL break_count: got %0d exp 0", acc8 - a); end
        n_chk++; if (pe8n + ov8n - e !== 0) begin n_fail++; $display("FAIL break_other_err: got %0d exp 0", pe8n + ov8n - e); end
        rsrx8 = 1'b1;
        idle(300);
        send8(8'h3C, 160, 1'b1);
        idle(200);
        n_chk++; if (acc8 - a !== 1) begin n_fail++; $display("FAIL after_break_count: got %0d exp 1", acc8 - a); end
        n_chk++; if (log8[a % 64] !== 8'h3C) begin n_fail++; $display("FAIL after_break_data: got %h exp 3c", log8[a % 64]); end
        n_chk++; if (fe8n - f !== 1) begin n_fail++; $display("FAIL after_break_ferr: got %0d exp 1", fe8n - f); end
    endtask

    task automatic test_backpressure;
        int a, o;
        a = acc8; o = ov8n;
        rdy8 = 1'b0;
        send8(8'h11, 160, 1'b1);
        send8(8'h22, 160, 1'b1);
        idle(200);
        n_chk++; if (val8 !== 1'b1) begin n_fail++; $display("FAIL bp_valid_held: got %b exp 1", val8); end
        n_chk++; if (data8 !== 8'h11) begin n_fail++; $display("FAIL bp_data_held: got %h exp 11", data8); end
        n_chk++; if (ov8n - o !== 1) begin n_fail++; $display("FAIL bp_overrun: got %0d exp 1", ov8n - o); end
        n_chk++; if (acc8 - a !== 0) begin n_fail++; $display("FAIL bp_no_accept: got %0d exp 0", acc8 - a); end
        @(posedge clk);
        #1 rdy8 = 1'b1;
        idle(3);
        n_chk++; if (acc8 - a !== 1) begin n_fail++; $display("FAIL bp_accept_count: got %0d exp 1", acc8 - a); end
        n_chk++; if (log8[a % 64] !== 8'h11) begin n_fail++; $display("FAIL bp_accept_data: got %h exp 11", log8[a % 64]); end
        n_chk++; if (val8 !== 1'b0) begin n_fail++; $display("FAIL bp_valid_fall: got %b exp 0", val8); end
    endtask

    task automatic test_reset_midframe;
        int a;
        rdy8 = 1'b0;
        send8(8'h5A, 160, 1'b1);
        idle(200);
        n_chk++; if (val8 !== 1'b1) begin n_fail++; $display("FAIL mid_pending: got %b exp 1", val8); end
        rsrx8 = 1'b0;
        idle(160);
        rsrx8 = 1'b1;
        idle(640);
        rst = 1'b1;
        idle(3);
        n_chk++; if (val8 !== 1'b0) begin n_fail++; $display("FAIL mid_rst_valid: got %b exp 0", val8); end
        n_chk++; if (data8 !== 8'h00) begin n_fail++; $display("FAIL mid_rst_data: got %h exp 00", data8); end
        n_chk++; if ({pe8, fe8, ov8} !== 3'b000) begin n_fail++; $display("FAIL mid_rst_err: got %b exp 000", {pe8, fe8, ov8}); end
        rst = 1'b0;
        @(posedge clk);
        #1 rdy8 = 1'b1;
        a = acc8;
        idle(1200);
        n_chk++; if (acc8 - a !== 0) begin n_fail++; $display("FAIL mid_partial_dropped: got %0d exp 0", acc8 - a); end
        send8(8'h0F, 160, 1'b1);
        idle(200);
        n_chk++; if (acc8 - a !== 1) begin n_fail++; $display("FAIL mid_next_count: got %0d exp 1", acc8 - a); end
        n_chk++; if (log8[a % 64] !== 8'h0F) begin n_fail++; $display("FAIL mid_next_data: got %h exp 0f", log8[a % 64]); end
    endtask

    task automatic test_skew;
        int a, e;
        a = acc8; e = pe8n + fe8n + ov8n;
        send8(8'h55, 157, 1'b1);
        send8(8'hAA, 163, 1'b1);
        send8(8'h55, 163, 1'b1);
        send8(8'hAA, 157, 1'b1);
        idle(300);
        n_chk++; if (acc8 - a !== 4) begin n_fail++; $display("FAIL skew_count: got %0d exp 4", acc8 - a); end
        n_chk++; if (log8[a % 64] !== 8'h55) begin n_fail++; $display("FAIL skew_fast55: got %h exp 55", log8[a % 64]); end
        n_chk++; if (log8[(a + 1) % 64] !== 8'hAA) begin n_fail++; $display("FAIL skew_slowAA: got %h exp aa", log8[(a + 1) % 64]); end
        n_chk++; if (log8[(a + 2) % 64] !== 8'h55) begin n_fail++; $display("FAIL skew_slow55: got %h exp 55", log8[(a + 2) % 64]); end
        n_chk++; if (log8[(a + 3) % 64] !== 8'hAA) begin n_fail++; $display("FAIL skew_fastAA: got %h exp aa", log8[(a + 3) % 64]); end
        n_chk++; if (pe8n + fe8n + ov8n - e !== 0) begin n_fail++; $display("FAIL skew_errors: got %0d exp 0", pe8n + fe8n + ov8n - e); end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_parity;
        test_glitch_break;
        test_backpressure;
        test_reset_midframe;
        test_skew;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx_param.md
# uart_rx_param

Parametrised UART receiver that converts the serial `RsRx` line into bytes for the TwentyFortyEight game controller (key-command decoding sits downstream). Generalises the fixed 8N1 receive path to configurable baud, data width, parity and oversampling, and adds:
- majority-vote sampling
- false-start rejection
- parity, framing and overrun detection
- a valid/ready output handshake

## Interface
- `CLK_HZ`, 100_000_000, system clock frequency.
- `BAUD`, 9600, line rate.
- `OVERSAMPLE`, 16, sample ticks per bit; even, ≥8.
- `DATA_BITS`, 8, payload bits per frame, 5–9, sent LSB first.
- `PARITY`, 0, 0 = none, 1 = odd, 2 = even.
- `clk  in  1` system clock; one clock, all logic on rising edge.
- `rst  in  1` reset, asynchronous, active-high.
- `RsRx  in  1` asynchronous serial input; idle high.
- `rx_data  out  DATA_BITS` received payload; valid while `rx_valid`.
- `rx_valid  out  1` payload available; held until accepted.
- `rx_ready  in  1` consumer accepts when `rx_valid && rx_ready`.
- `parity_err  out  1` one-cycle pulse: parity mismatch; byte dropped.
- `frame_err  out  1` one-cycle pulse: stop bit sampled low; byte dropped.
- `overrun  out  1` one-cycle pulse: good byte completed while previous one not accepted; new byte dropped.

## Operation
- `RsRx` passes a 2-flop synchroniser; both flops reset to 1. All decoding uses the synchronised signal.
- Tick generator divides `clk` by `DIV = round(CLK_HZ / (BAUD*OVERSAMPLE))`.
  - Counter resets to 0 and restarts on every IDLE→START transition, so ticks are phase-aligned to the start edge.
- Each bit value is the majority of 3 samples taken at ticks `OVERSAMPLE/2-1`, `OVERSAMPLE/2` and `OVERSAMPLE/2+1` within the bit.
- State machine:
  - **IDLE**: falling edge on the synchronised line → START.
  - **START**: at bit centre, majority 1 → false start, back to IDLE with no output. Majority 0 → DATA.
  - **DATA**: `DATA_BITS` bits shifted in LSB first; bit counter width `$clog2(DATA_BITS+1)`. Then → PARITY if `PARITY != 0`, else → STOP.
  - **PARITY**: one bit. Odd parity requires XOR(data, p) = 1; even parity requires XOR(data, p) = 0.
  - **STOP**: at bit centre:
    - majority 0 → `frame_err`, go to BREAK.
    - else parity bad → `parity_err`, go to IDLE.
    - else if `rx_valid && !rx_ready` → `overrun`, go to IDLE.
    - else load `rx_data`, set `rx_valid`, go to IDLE.
  - **BREAK**: wait for synchronised line = 1, then IDLE. Holding the line low never produces bytes.
- Parity and framing errors in the same frame: only `frame_err` pulses.
- Output register is cleared by the handshake.
  - If acceptance and a new good byte's load occur in the same cycle, the new byte loads, `rx_valid` stays 1, and there is no overrun.
- Reset, including mid-frame:
  - state IDLE, counters 0, synchroniser to 1
  - `rx_data = 0`, `rx_valid = 0`, all error pulses 0
  - any partial frame is discarded.

## Timing
- Synchroniser latency 2 cycles. START entered 3 cycles after the `RsRx` falling edge.
- `rx_valid` and the error pulses assert on the clock edge after the third stop-bit sample (≈ mid-stop-bit). Nominal edge-to-`rx_valid` ≈ (1 + DATA_BITS + P + 0.5)·OVERSAMPLE·DIV + 4 cycles, where P = 1 if `PARITY != 0`, else 0.
- A new start edge is accepted from the cycle after STOP. The receiver tolerates back-to-back frames with a half-bit stop.
- `rx_valid` falls the edge after the handshake. `rx_data` is stable while `rx_valid = 1`.
- Baud tolerance: ±2% total mismatch at OVERSAMPLE = 16.

## Structure
- Shared package or include `uart_pkg` holds:
  - parity-mode constants `PAR_NONE`, `PAR_ODD`, `PAR_EVEN`
  - state encoding `ST_IDLE`, `ST_START`, `ST_DATA`, `ST_PARITY`, `ST_STOP`, `ST_BREAK`
  - `DIV` calculation function
- These are reused by the planned `uart_tx_param`.
- One sub-module: `uart_baud_tick`. Parameters `DIV`. Ports: clk, rst, restart input, one-cycle tick output.

## Test plan
Bench parameters unless stated: `CLK_HZ = 1_600_000`, `BAUD = 10_000`, OVERSAMPLE 16, so DIV = 10 and a bit is 160 cycles. `rx_ready = 1` unless stated.
- **Basic 8N1**: send 0xA5 → `rx_data = 0xA5`, `rx_valid` one cycle; no error pulses.
- **Even parity, 7 data bits**: `PARITY = 2`, `DATA_BITS = 7`.
  - Send 0x53 with parity bit 0 → delivered.
  - Same frame with parity bit 1 → `parity_err` pulse, `rx_valid` stays 0.
- **Glitch and break**:
  - 40-cycle low glitch → no output, state returns to IDLE.
  - Stop bit driven 0 → `frame_err`; line held low 2000 cycles → no further output.
  - Line goes high, then 0x3C is sent → `rx_data = 0x3C`.
- **Backpressure**: `rx_ready = 0`; send 0x11 then 0x22 → `rx_valid` held with 0x11; `overrun` pulses at the 0x22 stop; raise `rx_ready` → 0x11 accepted, `rx_valid` falls.
- **Reset mid-frame**: assert `rst` for 3 cycles after bit 3 of 0xFF → all outputs 0; a subsequent 0x0F frame → `rx_data = 0x0F`.
- **Baud skew**: transmit 0x55 and 0xAA at ±2% of nominal bit period, back-to-back → both delivered correctly.
